// File: rtl/pipe_datapath.sv
// Two-stage pipelined datapath: register file, 8-op ALU with Z/N/C flags and a
// destination-source mux, valid/ready on both sides with full operand forwarding.
module pipe_datapath #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    rx,
  input  logic [AW-1:0]    ry,
  input  logic [2:0]       alu_op,
  input  logic [1:0]       dest_src,
  input  logic             reg_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [AW-1:0]    out_rd,
  output logic             out_wr,
  output logic [2:0]       flags
);

  logic [WIDTH-1:0] rf_q [NREG];

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_d_q;
  logic [AW-1:0]    s1_rx_q;
  logic [2:0]       s1_op_q;
  logic [1:0]       s1_src_q;
  logic             s1_wr_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic [AW-1:0]    s2_rd_q;
  logic             s2_wr_q;
  logic [2:0]       flags_q;

  logic             s1_adv, accept, fwd_a, fwd_b;
  logic [WIDTH:0]   alu_ext;
  logic [WIDTH-1:0] alu_res, mux_val, a_d, b_d;
  logic [2:0]       flags_d;

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  // bit WIDTH of alu_ext is the carry/borrow/shifted-out bit
  always_comb begin
    alu_ext = '0;
    case (s1_op_q)
      3'd0:    alu_ext = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      3'd1:    alu_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      3'd2:    alu_ext = {1'b0, s1_a_q & s1_b_q};
      3'd3:    alu_ext = {1'b0, s1_a_q | s1_b_q};
      3'd4:    alu_ext = {1'b0, s1_a_q ^ s1_b_q};
      3'd5:    alu_ext = {1'b0, ~s1_a_q};
      3'd6:    alu_ext = {s1_a_q, 1'b0};
      default: alu_ext = {s1_a_q[0], 1'b0, s1_a_q[WIDTH-1:1]};
    endcase
    alu_res = alu_ext[WIDTH-1:0];
    flags_d = {(alu_res == '0), alu_res[WIDTH-1], alu_ext[WIDTH]};
  end

  always_comb begin
    mux_val = s1_d_q;
    case (s1_src_q)
      2'd0:    mux_val = s1_d_q;
      2'd1:    mux_val = s1_b_q;
      2'd2:    mux_val = alu_res;
      default: mux_val = s1_a_q;
    endcase
  end

  // forward the value being written back on this same edge
  assign fwd_a = s1_adv && s1_wr_q && (s1_rx_q == rx);
  assign fwd_b = s1_adv && s1_wr_q && (s1_rx_q == ry);
  assign a_d   = fwd_a ? mux_val : rf_q[rx];
  assign b_d   = fwd_b ? mux_val : rf_q[ry];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_d_q     <= '0;
      s1_rx_q    <= '0;
      s1_op_q    <= '0;
      s1_src_q   <= '0;
      s1_wr_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_rd_q    <= '0;
      s2_wr_q    <= 1'b0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= a_d;
        s1_b_q     <= b_d;
        s1_d_q     <= data_in;
        s1_rx_q    <= rx;
        s1_op_q    <= alu_op;
        s1_src_q   <= dest_src;
        s1_wr_q    <= reg_write;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_data_q  <= mux_val;
        s2_rd_q    <= s1_rx_q;
        s2_wr_q    <= s1_wr_q;
        if (s1_wr_q) rf_q[s1_rx_q] <= mux_val;
        if (s1_src_q == 2'd2) flags_q <= flags_d;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign data_out  = s2_data_q;
  assign out_rd    = s2_rd_q;
  assign out_wr    = s2_wr_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: default 8x8 instance plus a 16x16 instance.
module tb_pipe_datapath;

  logic       clock = 1'b0;
  logic       resetn;
  logic       in_valid, in_ready, reg_write, out_valid, out_ready, out_wr;
  logic [7:0] data_in, data_out;
  logic [2:0] rx, ry, alu_op, out_rd, flags;
  logic [1:0] dest_src;

  logic        in_valid2, in_ready2, reg_write2, out_valid2, out_wr2;
  logic [15:0] data_in2, data_out2;
  logic [3:0]  rx2, ry2, out_rd2;
  logic [2:0]  alu_op2, flags2;
  logic [1:0]  dest_src2;

  int total = 0;
  int bad   = 0;
  logic [15:0] q[$];
  logic [15:0] q2[$];
  logic [3:0]  qrd2[$];

  always #5 clock = ~clock;

  pipe_datapath dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .rx(rx), .ry(ry), .alu_op(alu_op), .dest_src(dest_src),
    .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_rd(out_rd), .out_wr(out_wr), .flags(flags)
  );

  pipe_datapath #(.WIDTH(16), .NREG(16)) dut16 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid2), .in_ready(in_ready2),
    .data_in(data_in2), .rx(rx2), .ry(ry2), .alu_op(alu_op2), .dest_src(dest_src2),
    .reg_write(reg_write2), .out_valid(out_valid2), .out_ready(1'b1),
    .data_out(data_out2), .out_rd(out_rd2), .out_wr(out_wr2), .flags(flags2)
  );

  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) q.push_back({8'h00, data_out});
    if (resetn && out_valid2) begin
      q2.push_back(data_out2);
      qrd2.push_back(out_rd2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // call right after a rising edge; returns on the edge that accepted
  task automatic send(input logic [7:0] d, input logic [2:0] x, input logic [2:0] y,
                      input logic [2:0] op, input logic [1:0] src, input logic wr);
    bit ok;
    ok = 0;
    #1;
    in_valid = 1; data_in = d; rx = x; ry = y; alu_op = op; dest_src = src; reg_write = wr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle();
    #1 in_valid = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 100; i++) begin
      if (q.size() >= n) break;
      @(negedge clock);
    end
    chk("drain", 32'(q.size() >= n), 32'd1);
    @(negedge clock);
  endtask

  initial begin
    resetn = 0; in_valid = 0; out_ready = 1; data_in = 0; rx = 0; ry = 0;
    alu_op = 0; dest_src = 0; reg_write = 0;
    in_valid2 = 0; data_in2 = 0; rx2 = 0; ry2 = 0; alu_op2 = 0; dest_src2 = 0; reg_write2 = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_data_out", 32'(data_out), 0);
    @(negedge clock) resetn = 1;
    @(posedge clock);

    // back-to-back with forwarding
    send(8'h05, 3'd1, 3'd0, 3'd0, 2'd0, 1);
    send(8'h03, 3'd2, 3'd0, 3'd0, 2'd0, 1);
    send(8'h00, 3'd1, 3'd2, 3'd0, 2'd2, 1);
    send(8'h00, 3'd1, 3'd1, 3'd0, 2'd2, 1);
    send(8'h00, 3'd1, 3'd0, 3'd0, 2'd3, 0);
    idle();
    drain(5);
    chk("fwd_0", 32'(q[0]), 32'h05);
    chk("fwd_1", 32'(q[1]), 32'h03);
    chk("fwd_2", 32'(q[2]), 32'h08);
    chk("fwd_3", 32'(q[3]), 32'h10);
    chk("fwd_r1", 32'(q[4]), 32'h10);
    chk("fwd_flags", 32'(flags), 32'b000);
    q.delete();

    // SUB borrow, ADD overflow, shifts, flag persistence
    @(posedge clock);
    send(8'h03, 3'd1, 3'd0, 3'd0, 2'd0, 1);
    send(8'h05, 3'd2, 3'd0, 3'd0, 2'd0, 1);
    send(8'h00, 3'd1, 3'd2, 3'd1, 2'd2, 0);
    idle();
    drain(3);
    chk("sub_val", 32'(q[2]), 32'hFE);
    chk("sub_flags", 32'(flags), 32'b011);
    q.delete();
    @(posedge clock);
    send(8'hFF, 3'd3, 3'd0, 3'd0, 2'd0, 1);
    send(8'h01, 3'd4, 3'd0, 3'd0, 2'd0, 1);
    send(8'h00, 3'd3, 3'd4, 3'd0, 2'd2, 0);
    idle();
    drain(3);
    chk("addov_val", 32'(q[2]), 32'h00);
    chk("addov_flags", 32'(flags), 32'b101);
    q.delete();
    @(posedge clock);
    send(8'h01, 3'd5, 3'd0, 3'd0, 2'd0, 1);
    send(8'h00, 3'd5, 3'd0, 3'd7, 2'd2, 0);
    idle();
    drain(2);
    chk("shr_val", 32'(q[1]), 32'h00);
    chk("shr_flags", 32'(flags), 32'b101);
    q.delete();
    @(posedge clock);
    send(8'h81, 3'd6, 3'd0, 3'd0, 2'd0, 1);
    send(8'h00, 3'd6, 3'd0, 3'd6, 2'd2, 0);
    idle();
    drain(2);
    chk("shl_val", 32'(q[1]), 32'h02);
    chk("shl_flags", 32'(flags), 32'b001);
    q.delete();
    @(posedge clock);
    send(8'h55, 3'd7, 3'd0, 3'd0, 2'd0, 1);
    idle();
    drain(1);
    chk("load_val", 32'(q[0]), 32'h55);
    chk("load_keeps_flags", 32'(flags), 32'b001);
    q.delete();

    // backpressure: two held, third stalls
    @(posedge clock);
    #1 out_ready = 0;
    send(8'h11, 3'd0, 3'd0, 3'd0, 2'd0, 1);
    send(8'h22, 3'd1, 3'd0, 3'd0, 2'd0, 1);
    #1;
    in_valid = 1; data_in = 8'h33; rx = 3'd2; dest_src = 2'd0; reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(data_out), 32'h11);
      chk("bp_hold_rd", 32'(out_rd), 0);
    end
    @(posedge clock);
    #1 out_ready = 1;
    send(8'h33, 3'd2, 3'd0, 3'd0, 2'd0, 1);
    send(8'h44, 3'd3, 3'd0, 3'd0, 2'd0, 1);
    idle();
    drain(4);
    chk("bp_0", 32'(q[0]), 32'h11);
    chk("bp_1", 32'(q[1]), 32'h22);
    chk("bp_2", 32'(q[2]), 32'h33);
    chk("bp_3", 32'(q[3]), 32'h44);
    chk("bp_count", 32'(q.size()), 4);
    q.delete();

    // reset with two instructions in flight
    @(posedge clock);
    #1 out_ready = 0;
    send(8'hAA, 3'd5, 3'd0, 3'd0, 2'd0, 1);
    send(8'hBB, 3'd6, 3'd0, 3'd0, 2'd0, 1);
    idle();
    #1 resetn = 0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_flags", 32'(flags), 0);
    @(negedge clock) resetn = 1;
    q.delete();
    out_ready = 1;
    @(posedge clock);
    send(8'h00, 3'd5, 3'd0, 3'd0, 2'd3, 0);
    idle();
    drain(1);
    chk("mid_rst_r5", 32'(q[0]), 32'h00);
    chk("mid_rst_count", 32'(q.size()), 1);

    // 16-bit / 16-register instance
    @(posedge clock);
    #1;
    in_valid2 = 1; data_in2 = 16'h0000; rx2 = 4'hF; dest_src2 = 2'd0; reg_write2 = 1;
    @(negedge clock) chk("w16_rdy0", 32'(in_ready2), 1);
    @(posedge clock);
    #1;
    data_in2 = 16'h0001; rx2 = 4'hE;
    @(negedge clock) chk("w16_rdy1", 32'(in_ready2), 1);
    @(posedge clock);
    #1;
    data_in2 = 16'h0000; rx2 = 4'hF; ry2 = 4'hE; alu_op2 = 3'd1; dest_src2 = 2'd2; reg_write2 = 0;
    @(negedge clock) chk("w16_rdy2", 32'(in_ready2), 1);
    @(posedge clock);
    #1 in_valid2 = 0;
    for (int i = 0; i < 100; i++) begin
      if (q2.size() >= 3) break;
      @(negedge clock);
    end
    chk("w16_drain", 32'(q2.size() >= 3), 1);
    @(negedge clock);
    chk("w16_sub_val", 32'(q2[2]), 32'hFFFF);
    chk("w16_out_rd", 32'(qrd2[2]), 32'hF);
    chk("w16_flags", 32'(flags2), 32'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
